// File: rtl/uart_txd_sniffer.sv
// UART receive monitor: decodes the uart_txd stream (8N1, or 8E1 when
// UART_SNIFF_PARITY_EN is defined) into bytes buffered in a valid/ready FIFO.
module uart_txd_sniffer #(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          CLK100MHZ,
  input  logic                          fpga_rst,
  input  logic                          uart_txd,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int unsigned DIV   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
`ifdef UART_SNIFF_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [1:0]         r_sync;
  logic               w_s;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_cnt_zero;
  logic [2:0]         r_bit;
  logic [7:0]         r_shift;
  logic               w_bit_clr;
  logic               w_shift_en;
  logic               w_push;
  logic               w_frame_err;
`ifdef UART_SNIFF_PARITY_EN
  logic               r_par_err;
  logic               w_par_chk;
`endif

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW-1:0]      w_rd_next;
  logic [CW-1:0]      r_count;
  logic [CW-1:0]      w_count_next;
  logic               w_pop;
  logic               w_full;
  logic               w_wr_en;
  logic               w_drop;
  logic [7:0]         w_head_next;
  logic [7:0]         r_rx_data;
  logic               r_rx_valid;
  logic               r_frame_err;
  logic               r_overflow;
  logic               r_busy;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge CLK100MHZ or negedge fpga_rst) begin
    if (!fpga_rst) r_sync <= 2'b11;
    else           r_sync <= {r_sync[0], uart_txd};
  end
  assign w_s        = r_sync[1];
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge CLK100MHZ or negedge fpga_rst) begin
    if (!fpga_rst) r_state <= S_IDLE;
    else           r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (!w_s) w_state_next = S_START;
      S_START:     if (w_cnt_zero) w_state_next = w_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (w_cnt_zero && r_bit == 3'd7) begin
`ifdef UART_SNIFF_PARITY_EN
          w_state_next = S_PARITY;
`else
          w_state_next = S_STOP;
`endif
        end
      end
`ifdef UART_SNIFF_PARITY_EN
      S_PARITY:    if (w_cnt_zero) w_state_next = S_STOP;
`endif
      S_STOP:      if (w_cnt_zero) w_state_next = w_s ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (w_s) w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  // Baud counter reloads and per-state sample strobes.
  always_comb begin
    w_cnt_next  = w_cnt_zero ? r_cnt : r_cnt - CNT_W'(1);
    w_bit_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_push      = 1'b0;
    w_frame_err = 1'b0;
`ifdef UART_SNIFF_PARITY_EN
    w_par_chk   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (!w_s) begin
          w_cnt_next = CNT_W'(HALF - 1);
          w_bit_clr  = 1'b1;
        end
      end
      S_START: begin
        if (w_cnt_zero && !w_s) w_cnt_next = CNT_W'(DIV - 1);
      end
      S_DATA: begin
        if (w_cnt_zero) begin
          w_shift_en = 1'b1;
          w_cnt_next = CNT_W'(DIV - 1);
        end
      end
`ifdef UART_SNIFF_PARITY_EN
      S_PARITY: begin
        if (w_cnt_zero) begin
          w_par_chk  = 1'b1;
          w_cnt_next = CNT_W'(DIV - 1);
        end
      end
      S_STOP: begin
        if (w_cnt_zero) begin
          w_push      = w_s & ~r_par_err;
          w_frame_err = ~w_s | r_par_err;
        end
      end
`else
      S_STOP: begin
        if (w_cnt_zero) begin
          w_push      = w_s;
          w_frame_err = ~w_s;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge fpga_rst) begin
    if (!fpga_rst) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_cnt <= w_cnt_next;
      if (w_bit_clr)       r_bit <= '0;
      else if (w_shift_en) r_bit <= r_bit + 3'd1;
      if (w_shift_en) r_shift <= {w_s, r_shift[7:1]};
    end
  end

`ifdef UART_SNIFF_PARITY_EN
  // Even parity: the received parity bit must equal the XOR of the data bits.
  always_ff @(posedge CLK100MHZ or negedge fpga_rst) begin
    if (!fpga_rst)      r_par_err <= 1'b0;
    else if (w_bit_clr) r_par_err <= 1'b0;
    else if (w_par_chk) r_par_err <= w_s ^ (^r_shift);
  end
`endif

  assign w_pop     = r_rx_valid & rx_ready;
  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_wr_en   = w_push & (~w_full | w_pop);
  assign w_drop    = w_push & w_full & ~w_pop;
  assign w_rd_next = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;

  always_comb begin
    w_count_next = r_count;
    case ({w_wr_en, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Head bypass: a byte written into an otherwise empty FIFO becomes the head directly.
  assign w_head_next = (w_wr_en && r_wr_ptr == w_rd_next) ? r_shift : r_mem[w_rd_next];

  always_ff @(posedge CLK100MHZ) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge CLK100MHZ or negedge fpga_rst) begin
    if (!fpga_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr    <= w_rd_next;
      r_count     <= w_count_next;
      if (w_count_next != '0) r_rx_data <= w_head_next;
      r_rx_valid  <= (w_count_next != '0);
      r_frame_err <= w_frame_err;
      if (w_drop) r_overflow <= 1'b1;
      r_busy      <= (w_state_next != S_IDLE);
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign frame_err  = r_frame_err;
  assign overflow   = r_overflow;
  assign fifo_count = r_count;
  assign busy       = r_busy;

endmodule

// File: tb/tb_uart_txd_sniffer.sv
// Directed bench for uart_txd_sniffer at DIV=10, FIFO_DEPTH=4; parity cases
// are built when UART_SNIFF_PARITY_EN is defined.
module tb_uart_txd_sniffer;

  localparam int unsigned DIV = 10;

  logic       clk = 1'b0;
  logic       fpga_rst;
  logic       uart_txd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overflow;
  logic [2:0] fifo_count;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int fe_cnt   = 0;
  int busy_cnt = 0;
  int fe_base;
  int busy_base;

  uart_txd_sniffer #(
    .CLK_HZ     (100000000),
    .BAUD       (10000000),
    .FIFO_DEPTH (4)
  ) dut (
    .CLK100MHZ  (clk),
    .fpga_rst   (fpga_rst),
    .uart_txd   (uart_txd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .fifo_count (fifo_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (busy)      busy_cnt <= busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Advance n clock edges and settle 1 ns past the last one.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame with a correct parity bit (when enabled); the stop level/length are caller-chosen.
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_len);
    uart_txd = 1'b0;
    cycles(DIV);
    for (int i = 0; i < 8; i++) begin
      uart_txd = b[i];
      cycles(DIV);
    end
`ifdef UART_SNIFF_PARITY_EN
    uart_txd = ^b;
    cycles(DIV);
`endif
    uart_txd = stop_val;
    cycles(stop_len);
  endtask

`ifdef UART_SNIFF_PARITY_EN
  task automatic send_par(input logic [7:0] b, input logic pbit);
    uart_txd = 1'b0;
    cycles(DIV);
    for (int i = 0; i < 8; i++) begin
      uart_txd = b[i];
      cycles(DIV);
    end
    uart_txd = pbit;
    cycles(DIV);
    uart_txd = 1'b1;
    cycles(DIV);
  endtask
`endif

  task automatic pop_one();
    rx_ready = 1'b1;
    cycles(1);
    rx_ready = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_data"},  32'(rx_data),    32'h0);
    check({tag, "_valid"}, 32'(rx_valid),   32'h0);
    check({tag, "_ferr"},  32'(frame_err),  32'h0);
    check({tag, "_ovf"},   32'(overflow),   32'h0);
    check({tag, "_count"}, 32'(fifo_count), 32'h0);
    check({tag, "_busy"},  32'(busy),       32'h0);
  endtask

  initial begin
    logic [7:0] b2b [4];
    logic [7:0] fill [4];
    logic [7:0] c3;
    b2b  = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
    fill = '{8'h11, 8'h22, 8'h33, 8'h44};
    c3   = 8'hC3;

    fpga_rst = 1'b0;
    uart_txd = 1'b1;
    rx_ready = 1'b0;
    cycles(3);
    check_reset_vals("rst");
    fpga_rst = 1'b1;
    cycles(5);

    // Single byte, then one-cycle accept.
    fe_base = fe_cnt;
    send_frame(8'h55, 1'b1, DIV);
    cycles(2);
    check("s1_valid", 32'(rx_valid),   32'h1);
    check("s1_data",  32'(rx_data),    32'h55);
    check("s1_count", 32'(fifo_count), 32'h1);
    check("s1_ferr",  32'(fe_cnt - fe_base), 32'h0);
    pop_one();
    check("s1_pop_count", 32'(fifo_count), 32'h0);
    check("s1_pop_valid", 32'(rx_valid),   32'h0);

    // Back-to-back frames with the consumer stalled, then drain in order.
    for (int i = 0; i < 4; i++) send_frame(b2b[i], 1'b1, DIV);
    cycles(2);
    check("b2b_count", 32'(fifo_count), 32'h4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b2b_data%0d", i), 32'(rx_data), 32'(b2b[i]));
      pop_one();
    end
    check("b2b_empty", 32'(rx_valid), 32'h0);

    // Three-cycle glitch: busy pulses, nothing else happens.
    fe_base   = fe_cnt;
    busy_base = busy_cnt;
    uart_txd  = 1'b0;
    cycles(3);
    uart_txd  = 1'b1;
    cycles(12);
    check("gl_busy_seen", 32'(busy_cnt - busy_base > 0), 32'h1);
    check("gl_count",     32'(fifo_count), 32'h0);
    check("gl_ferr",      32'(fe_cnt - fe_base), 32'h0);
    check("gl_idle",      32'(busy), 32'h0);

    // Stop bit held low: one frame_err, no push, idle only once line is high.
    fe_base = fe_cnt;
    send_frame(8'h12, 1'b0, 30);
    check("fr_wait_busy", 32'(busy), 32'h1);
    uart_txd = 1'b1;
    cycles(5);
    check("fr_idle",  32'(busy), 32'h0);
    check("fr_ferr",  32'(fe_cnt - fe_base), 32'h1);
    check("fr_count", 32'(fifo_count), 32'h0);

    // Overflow: the fifth byte is dropped and overflow sticks.
    for (int i = 0; i < 4; i++) send_frame(fill[i], 1'b1, DIV);
    cycles(2);
    check("ov_pre", 32'(overflow), 32'h0);
    send_frame(8'h77, 1'b1, DIV);
    cycles(2);
    check("ov_flag",  32'(overflow),   32'h1);
    check("ov_count", 32'(fifo_count), 32'h4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ov_data%0d", i), 32'(rx_data), 32'(fill[i]));
      pop_one();
    end
    check("ov_empty",  32'(rx_valid), 32'h0);
    check("ov_sticky", 32'(overflow), 32'h1);

    // Reset during data bit 4 of 0xC3.
    uart_txd = 1'b0;
    cycles(DIV);
    for (int i = 0; i < 4; i++) begin
      uart_txd = c3[i];
      cycles(DIV);
    end
    uart_txd = c3[4];
    cycles(3);
    check("mid_busy", 32'(busy), 32'h1);
    fpga_rst = 1'b0;
    cycles(1);
    check_reset_vals("mid");
    uart_txd = 1'b1;
    cycles(3);
    fpga_rst = 1'b1;
    cycles(5);
    send_frame(8'h81, 1'b1, DIV);
    cycles(2);
    check("post_valid", 32'(rx_valid),   32'h1);
    check("post_data",  32'(rx_data),    32'h81);
    check("post_count", 32'(fifo_count), 32'h1);
    pop_one();

`ifdef UART_SNIFF_PARITY_EN
    fe_base = fe_cnt;
    send_par(8'h07, 1'b1);
    cycles(2);
    check("par_ok_count", 32'(fifo_count), 32'h1);
    check("par_ok_data",  32'(rx_data),    32'h07);
    check("par_ok_ferr",  32'(fe_cnt - fe_base), 32'h0);
    pop_one();
    send_par(8'h07, 1'b0);
    cycles(2);
    check("par_bad_ferr",  32'(fe_cnt - fe_base), 32'h1);
    check("par_bad_count", 32'(fifo_count), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
